// File: rtl/count_one_pkg.sv
// count_one_pkg
//   Shared types and helpers for the count_one streaming counter.
//   mode_t    : selects what each beat counts (all ones, ones from bit 0,
//               ones from the MSB, all zeros).
//   cnt_width : bits needed to hold a count in 0..w inclusive.
package count_one_pkg;

  typedef enum logic [1:0] {
    MODE_ALL  = 2'd0,
    MODE_CONT = 2'd1,
    MODE_LEAD = 2'd2,
    MODE_ZERO = 2'd3
  } mode_t;

  // A count can reach w itself, hence one bit more than $clog2(w).
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/count_one_mode.sv
// count_one_mode
//   Combinational per-beat counter.
//   data  : bits to count
//   mode  : MODE_ALL  -> popcount(data)
//           MODE_CONT -> run of ones starting at bit 0
//           MODE_LEAD -> run of ones starting at bit WIDTH-1
//           MODE_ZERO -> popcount(~data)
//   count : result, 0..WIDTH
module count_one_mode
  import count_one_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]            data,
  input  mode_t                       mode,
  output logic [cnt_width(WIDTH)-1:0] count
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] cont_cnt;
  logic [CW-1:0] lead_cnt;
  logic          run_lo;
  logic          run_hi;

  // One pass over the word builds all three counts. The run flags stay high
  // only while every bit seen so far from that end has been a one.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned (no latch), and blocking '=' is used so each iteration
    // sees the value written by the previous one.
    ones_cnt = '0;
    cont_cnt = '0;
    lead_cnt = '0;
    run_lo   = 1'b1;
    run_hi   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + CW'(data[i]);
      run_lo   = run_lo & data[i];
      cont_cnt = cont_cnt + CW'(run_lo);
      run_hi   = run_hi & data[WIDTH-1-i];
      lead_cnt = lead_cnt + CW'(run_hi);
    end
  end

  always_comb begin
    count = ones_cnt;
    case (mode)
      MODE_ALL:  count = ones_cnt;
      MODE_CONT: count = cont_cnt;
      MODE_LEAD: count = lead_cnt;
      MODE_ZERO: count = CW'(WIDTH) - ones_cnt;
      default:   count = ones_cnt;
    endcase
  end

endmodule

// File: rtl/count_one_stream.sv
// count_one_stream
//   Pipelined multi-mode bit counter with valid/ready flow control and a
//   saturating per-packet running total.
//
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake; beat accepted when both are high
//   in_data             : bits to count
//   in_mode             : counting mode (mode_t)
//   in_last             : beat closes the current packet
//   out_valid/out_ready : output handshake
//   out_count           : per-beat count
//   out_total           : packet running total including this beat,
//                         clamped to 2^TOTAL_WIDTH-1
//   out_sat             : total has saturated (sticky within the packet)
//   out_last            : in_last of this beat
//
//   A beat spends STAGES cycles in the pipe. Stage 0 registers the count;
//   the remaining stages are delay registers; the final stage also adds the
//   count into the packet accumulator as the beat enters it.
module count_one_stream
  import count_one_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int STAGES      = 2,
  parameter int TOTAL_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  mode_t                       in_mode,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_width(WIDTH)-1:0] out_count,
  output logic [TOTAL_WIDTH-1:0]      out_total,
  output logic                        out_sat,
  output logic                        out_last
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]          mode_count;
  logic [STAGES-1:0]      stage_valid;
  logic [STAGES-1:0]      stage_last;
  logic [CW-1:0]          stage_count [STAGES];
  logic [STAGES-1:0]      adv;

  logic [TOTAL_WIDTH-1:0] acc_q;
  logic                   sat_acc_q;
  logic [TOTAL_WIDTH-1:0] total_q;
  logic                   sat_q;

  count_one_mode #(
    .WIDTH (WIDTH)
  ) u_mode (
    .data  (in_data),
    .mode  (in_mode),
    .count (mode_count)
  );

  // A stage may load when the next one is moving or it holds nothing.
  // Built from the output back so in_ready depends on out_ready and the
  // registered valids only, never on in_valid.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready || !stage_valid[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] || !stage_valid[i];
    end
  end

  assign in_ready = adv[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          valid_r;
    logic          last_r;
    logic [CW-1:0] count_r;
    logic          prev_valid;
    logic          prev_last;
    logic [CW-1:0] prev_count;

    if (i == 0) begin : g_src_in
      assign prev_valid = in_valid;
      assign prev_last  = in_last;
      assign prev_count = mode_count;
    end else begin : g_src_stage
      assign prev_valid = stage_valid[i-1];
      assign prev_last  = stage_last[i-1];
      assign prev_count = stage_count[i-1];
    end

    if (i < STAGES - 1) begin : g_delay
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values and stage order in the source is irrelevant.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          count_r <= '0;
        end else if (adv[i]) begin
          valid_r <= prev_valid;
          if (prev_valid) begin
            last_r  <= prev_last;
            count_r <= prev_count;
          end
        end
      end
    end else begin : g_final
      // Sum one bit wider than the accumulator; its MSB flags overflow.
      logic [TOTAL_WIDTH:0]   sum;
      logic [TOTAL_WIDTH-1:0] new_total;
      logic                   new_sat;

      assign sum       = {1'b0, acc_q} + {{(TOTAL_WIDTH + 1 - CW){1'b0}}, prev_count};
      assign new_total = sum[TOTAL_WIDTH] ? {TOTAL_WIDTH{1'b1}} : sum[TOTAL_WIDTH-1:0];
      assign new_sat   = sat_acc_q | sum[TOTAL_WIDTH];

      // Everything here only moves with adv, so a stalled result holds and
      // the accumulator is not charged twice for the same beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_r   <= 1'b0;
          last_r    <= 1'b0;
          count_r   <= '0;
          total_q   <= '0;
          sat_q     <= 1'b0;
          acc_q     <= '0;
          sat_acc_q <= 1'b0;
        end else if (adv[i]) begin
          valid_r <= prev_valid;
          if (prev_valid) begin
            last_r  <= prev_last;
            count_r <= prev_count;
            total_q <= new_total;
            sat_q   <= new_sat;
            if (prev_last) begin
              acc_q     <= '0;
              sat_acc_q <= 1'b0;
            end else begin
              acc_q     <= new_total;
              sat_acc_q <= new_sat;
            end
          end
        end
      end
    end

    assign stage_valid[i] = valid_r;
    assign stage_last[i]  = last_r;
    assign stage_count[i] = count_r;
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_last  = stage_last[STAGES-1];
  assign out_count = stage_count[STAGES-1];
  assign out_total = total_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_count_one_stream.sv
// tb_count_one_stream
//   Two instances: dut_a (WIDTH=3, STAGES=1) for the exhaustive mode table,
//   dut_b (WIDTH=8, STAGES=3, TOTAL_WIDTH=4) for packets, saturation,
//   backpressure, random traffic against a reference model, and reset.
module tb_count_one_stream;
  import count_one_pkg::*;

  localparam int AW  = 3;
  localparam int AS  = 1;
  localparam int AT  = 16;
  localparam int ACW = cnt_width(AW);
  localparam int BW  = 8;
  localparam int BS  = 3;
  localparam int BT  = 4;
  localparam int BCW = cnt_width(BW);
  localparam int BMAX = (1 << BT) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           a_in_valid, a_in_ready, a_in_last;
  logic [AW-1:0]  a_in_data;
  mode_t          a_in_mode;
  logic           a_out_valid, a_out_ready, a_out_sat, a_out_last;
  logic [ACW-1:0] a_out_count;
  logic [AT-1:0]  a_out_total;

  logic           b_in_valid, b_in_ready, b_in_last;
  logic [BW-1:0]  b_in_data;
  mode_t          b_in_mode;
  logic           b_out_valid, b_out_ready, b_out_sat, b_out_last;
  logic [BCW-1:0] b_out_count;
  logic [BT-1:0]  b_out_total;

  count_one_stream #(.WIDTH(AW), .STAGES(AS), .TOTAL_WIDTH(AT)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_mode(a_in_mode), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_total(a_out_total), .out_sat(a_out_sat), .out_last(a_out_last)
  );

  count_one_stream #(.WIDTH(BW), .STAGES(BS), .TOTAL_WIDTH(BT)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_mode(b_in_mode), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_total(b_out_total), .out_sat(b_out_sat), .out_last(b_out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- reference model (dut_b) ----------------
  function automatic int ref_count(input logic [BW-1:0] d, input mode_t m);
    int n = 0;
    case (m)
      MODE_ALL:  for (int k = 0; k < BW; k++) n += int'(d[k]);
      MODE_CONT: while (n < BW && d[n] == 1'b1) n++;
      MODE_LEAD: while (n < BW && d[BW-1-n] == 1'b1) n++;
      default:   for (int k = 0; k < BW; k++) n += int'(!d[k]);
    endcase
    return n;
  endfunction

  typedef struct {
    int cnt;
    int tot;
    bit sat;
    bit last;
  } exp_t;

  exp_t sbq[$];
  int   m_acc = 0;
  bit   m_sat = 1'b0;
  bit   sb_en = 1'b0;
  bit   hold_pend = 1'b0;
  logic [31:0] hold_val;
  bit   saw_stall = 1'b0;

  // Handshakes are sampled on the falling edge; they complete on the next rise.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (b_out_valid && b_out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_count", b_out_count, e.cnt);
          check("sb_total", b_out_total, e.tot);
          check("sb_sat",   b_out_sat,   e.sat);
          check("sb_last",  b_out_last,  e.last);
        end
      end
      if (hold_pend)
        check("sb_hold", {21'd0, b_out_valid, b_out_count, b_out_total, b_out_sat, b_out_last}, hold_val);
      hold_pend = b_out_valid && !b_out_ready;
      hold_val  = {21'd0, b_out_valid, b_out_count, b_out_total, b_out_sat, b_out_last};
      if (!b_in_ready) saw_stall = 1'b1;
      if (b_in_valid && b_in_ready) begin
        exp_t e;
        int   sum;
        e.cnt  = ref_count(b_in_data, b_in_mode);
        sum    = m_acc + e.cnt;
        e.tot  = (sum > BMAX) ? BMAX : sum;
        e.sat  = m_sat || (sum > BMAX);
        e.last = b_in_last;
        sbq.push_back(e);
        if (b_in_last) begin
          m_acc = 0;
          m_sat = 1'b0;
        end else begin
          m_acc = e.tot;
          m_sat = e.sat;
        end
      end
    end
  end

  // ---------------- dut_b helpers ----------------
  task automatic b_send(input string nm, input logic [BW-1:0] d, input mode_t m, input logic l);
    logic r;
    bit   ok = 1'b0;
    b_in_data  = d;
    b_in_mode  = m;
    b_in_last  = l;
    b_in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      r = b_in_ready;
      @(posedge clk);
      #1;
      if (r) ok = 1'b1;
    end
    b_in_valid = 1'b0;
    check({nm, "_accept"}, ok, 1);
  endtask

  // Waits (bounded) for a result, then checks it; lat < 0 skips latency.
  task automatic b_expect(input string nm, input int cnt, input int tot, input int sat,
                          input int last, input int lat);
    int cyc = 0;
    while (!b_out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_valid"}, b_out_valid, 1);
    if (lat >= 0) check({nm, "_latency"}, cyc, lat);
    check({nm, "_count"}, b_out_count, cnt);
    check({nm, "_total"}, b_out_total, tot);
    check({nm, "_sat"},   b_out_sat,   sat);
    check({nm, "_last"},  b_out_last,  last);
  endtask

  task automatic b_beat(input string nm, input logic [BW-1:0] d, input mode_t m, input logic l,
                        input int cnt, input int tot, input int sat, input int lat);
    b_send(nm, d, m, l);
    b_expect(nm, cnt, tot, sat, int'(l), lat);
  endtask

  // Streams beats; pattern=1 gives out_ready 1,0,0,1 with a continuous input
  // stream of incrementing data, pattern=0 gives random traffic.
  task automatic run_stream(input int ncyc, input bit pattern);
    bit   fire = 1'b0;
    logic [BW-1:0] seq = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (pattern) b_out_ready = (c % 4 == 0) || (c % 4 == 3);
      else         b_out_ready = ($urandom_range(0, 3) != 0);
      if (!b_in_valid || fire) begin
        b_in_valid = pattern ? 1'b1 : ($urandom_range(0, 3) != 0);
        b_in_data  = pattern ? seq : BW'($urandom);
        b_in_mode  = mode_t'($urandom_range(0, 3));
        b_in_last  = ($urandom_range(0, 3) == 0);
        seq++;
      end
      @(negedge clk);
      fire = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int t = 0; t < 40 && sbq.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("sb_drain_empty", sbq.size(), 0);
  endtask

  // ---------------- dut_a table ----------------
  typedef struct {
    logic [AW-1:0] data;
    mode_t         mode;
    int            exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int all_exp  [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
    int cont_exp [8] = '{0, 1, 0, 2, 0, 1, 0, 3};
    int lead_exp [8] = '{0, 0, 0, 0, 1, 1, 2, 3};
    vec_t v;

    a_in_valid = 0; a_in_data = '0; a_in_mode = MODE_ALL; a_in_last = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = MODE_ALL; b_in_last = 0; b_out_ready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_count", b_out_count, 0);
    check("rst_b_out_total", b_out_total, 0);
    check("rst_b_out_sat",   b_out_sat,   0);
    check("rst_b_out_last",  b_out_last,  0);
    check("rst_a_out_valid", a_out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_in_ready", b_in_ready, 1);
    @(posedge clk);
    #1;

    // Mode table on dut_a: single-beat packets, one per cycle, so the total
    // equals the count and every result arrives one edge after acceptance.
    for (int k = 0; k < 8; k++) begin
      v.data = AW'(k); v.mode = MODE_ALL;  v.exp = all_exp[k];  tbl.push_back(v);
    end
    for (int k = 0; k < 8; k++) begin
      v.data = AW'(k); v.mode = MODE_CONT; v.exp = cont_exp[k]; tbl.push_back(v);
    end
    for (int k = 0; k < 8; k++) begin
      v.data = AW'(k); v.mode = MODE_LEAD; v.exp = lead_exp[k]; tbl.push_back(v);
    end
    v.data = 3'b000; v.mode = MODE_ZERO; v.exp = 3; tbl.push_back(v);
    v.data = 3'b101; v.mode = MODE_ZERO; v.exp = 1; tbl.push_back(v);

    foreach (tbl[k]) begin
      a_in_valid = 1'b1;
      a_in_data  = tbl[k].data;
      a_in_mode  = tbl[k].mode;
      a_in_last  = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("a_valid[%0d]", k), a_out_valid, 1);
      check($sformatf("a_count[%0d] mode %0d data %0d", k, tbl[k].mode, tbl[k].data), a_out_count, tbl[k].exp);
      check($sformatf("a_total[%0d]", k), a_out_total, tbl[k].exp);
      check($sformatf("a_last[%0d]", k), a_out_last, 1);
    end
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("a_drained_valid", a_out_valid, 0);

    // Packet accumulation on dut_b
    b_beat("pkt0", 8'hFF, MODE_ALL, 1'b0, 8, 8, 0, BS - 1);
    b_beat("pkt1", 8'h0F, MODE_ALL, 1'b0, 4, 12, 0, BS - 1);
    b_beat("pkt2", 8'h01, MODE_ALL, 1'b1, 1, 13, 0, BS - 1);
    b_beat("single", 8'h03, MODE_ALL, 1'b1, 2, 2, 0, BS - 1);

    // Mixed modes within one packet
    b_beat("mix0", 8'hC0, MODE_LEAD, 1'b0, 2, 2, 0, -1);
    b_beat("mix1", 8'h0F, MODE_ZERO, 1'b0, 4, 6, 0, -1);
    b_beat("mix2", 8'h07, MODE_CONT, 1'b1, 3, 9, 0, -1);

    // Saturation at 2^4-1
    b_beat("sat0", 8'hFF, MODE_ALL, 1'b0, 8, 8, 0, -1);
    b_beat("sat1", 8'hFF, MODE_ALL, 1'b0, 8, 15, 1, -1);
    b_beat("sat2", 8'h01, MODE_ALL, 1'b1, 1, 15, 1, -1);
    b_beat("sat_next", 8'h00, MODE_ALL, 1'b1, 0, 0, 0, -1);
    @(posedge clk);
    #1;

    // Backpressure pattern then random traffic, both against the model
    m_acc = 0;
    m_sat = 1'b0;
    hold_pend = 1'b0;
    sb_en = 1'b1;
    run_stream(64, 1'b1);
    check("bp_in_ready_dropped", saw_stall, 1);
    run_stream(2000, 1'b0);
    sb_en = 1'b0;

    // Reset mid-packet with two beats in flight
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
    b_send("mid0", 8'hFF, MODE_ALL, 1'b0);
    b_send("mid1", 8'h0F, MODE_ALL, 1'b0);
    b_expect("mid_pre", 8, 8, 0, 0, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", b_out_valid, 0);
    check("mid_rst_out_total", b_out_total, 0);
    check("mid_rst_out_count", b_out_count, 0);
    check("mid_rst_out_sat",   b_out_sat,   0);
    check("mid_rst_out_last",  b_out_last,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    #1;
    check("mid_rel_in_ready", b_in_ready, 1);
    b_beat("post_rst", 8'h03, MODE_ALL, 1'b1, 2, 2, 0, BS - 1);
    @(posedge clk);
    #1;
    check("post_rst_drained", b_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_one_stream.md
# count_one_stream

Pipelined, multi-mode bit counter with valid/ready flow control and per-packet accumulation. Each accepted beat is counted under one of four modes: all ones, contiguous ones from bit 0, contiguous ones from the MSB, or all zeros. The block also keeps a saturating running total across the beats of a packet. It is the streaming successor to the combinational one-counter, used where counts feed a registered pipeline, such as allocation and free-list bookkeeping or mask statistics.

## Interface
- WIDTH, 32: data width in bits; must be ≥ 2.
- STAGES, 2: beat latency in cycles; legal range 1..4.
- TOTAL_WIDTH, 16: width of the packet accumulator; must be ≥ $clog2(WIDTH)+1.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  WIDTH  bits to count.
- in_mode  in  2  counting mode (count_one_pkg::mode_t).
- in_last  in  1  beat closes the current packet.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_count  out  $clog2(WIDTH)+1  per-beat count.
- out_total  out  TOTAL_WIDTH  packet running total, including this beat.
- out_sat  out  1  packet total has saturated (sticky within the packet).
- out_last  out  1  copy of in_last for this beat.

## Operation
- Modes:
  - MODE_ALL (0): popcount of in_data.
  - MODE_CONT (1): number of consecutive 1s starting at bit 0. Example: 3'b011 → 2, 3'b010 → 0, 3'b101 → 1.
  - MODE_LEAD (2): number of consecutive 1s starting at bit WIDTH-1.
  - MODE_ZERO (3): popcount of ~in_data.
- Range: every count lies in 0..WIDTH. An all-ones input gives WIDTH in modes 0, 1 and 2; all-zeros gives WIDTH in mode 3.
- Beat accept: a beat is accepted when in_valid && in_ready.
- Stage 1 registers the count, last flag and valid bit. Stages 2..STAGES are delay registers.
- Accumulation when a beat enters the final stage:
  - Sum = acc + count, computed at TOTAL_WIDTH+1 bits.
  - If the sum exceeds 2^TOTAL_WIDTH−1, out_total is clamped to 2^TOTAL_WIDTH−1 and out_sat is set.
  - out_sat = sat_acc OR the new saturation.
- After a beat with last enters the final stage, acc and sat_acc clear to 0, so the next beat starts a new packet. Otherwise acc takes the new total and sat_acc takes out_sat.
- A packet may be a single beat (in_last=1). In that case out_total = out_count.
- Modes may differ between beats of one packet. The accumulator sums whatever is counted.

## Timing
- Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES−1, i.e. visible in the cycle following STAGES edges. There is no bubble with out_ready held at 1.
- Throughput: one beat per cycle with out_ready=1.
- Stall chain:
  - adv[STAGES−1] = out_ready || !valid[STAGES−1].
  - adv[i] = adv[i+1] || !valid[i].
  - in_ready = adv[0], combinational from out_ready. There is no combinational path from in_valid to in_ready.
- Output hold: while out_valid && !out_ready, every out_* output holds stable and the accumulator does not update.
- Simultaneous events: a beat leaving the final stage and a new beat entering it in the same cycle is normal. The accumulator takes the value for the entering beat.
- Reset values, mid-operation included:
  - All stage valids = 0, so out_valid = 0 and in-flight beats are dropped.
  - acc = 0, sat_acc = 0.
  - out_count = 0, out_total = 0, out_sat = 0, out_last = 0.
  - in_ready = 1 once reset is released.

## Structure
- Package count_one_pkg holds:
  - typedef enum logic[1:0] mode_t {MODE_ALL, MODE_CONT, MODE_LEAD, MODE_ZERO}.
  - Function cnt_width(w) returning $clog2(w)+1.
- Sub-module count_one_mode: combinational, parameter WIDTH; inputs data and mode; output count. Instantiated once ahead of stage 1.
- The stage registers are a generate loop over STAGES. The accumulator and saturation logic sit in the final stage.

## Test plan
- WIDTH=3, STAGES=1, out_ready=1, MODE_ALL over inputs 000..111 → counts 0,1,1,2,1,2,2,3; each result appears 1 cycle after accept.
- WIDTH=3, MODE_CONT over 000..111 → 0,1,0,2,0,1,0,3. MODE_LEAD over 000..111 → 0,0,0,0,1,1,2,3. MODE_ZERO on 000 → 3.
- WIDTH=8, STAGES=3, packet of 3 MODE_ALL beats 0xFF, 0x0F, 0x01 with last on the third → out_total 8, 12, 13; out_last=1 only on the third. The next single-beat packet 0x03 gives total 2.
- Backpressure: out_ready toggles 1,0,0,1 with a continuous input stream → outputs hold during stalls, in_ready drops when the pipe is full, and no beat is lost or duplicated (sequence checked by a scoreboard).
- TOTAL_WIDTH=4, WIDTH=8, beats 0xFF, 0xFF, 0x01 (last) → totals 8, 15 with out_sat=1, then 15 with out_sat=1. The next packet starts at 0 with out_sat=0.
- Assert rst_n mid-packet with 2 beats in flight → out_valid=0 and out_total=0 immediately. After release, beat 0x03 (last) gives total 2.
